score_timer: RTL

SCORE_TIMER -- requirements
Module: score_timer

---
 rtl/wam_pkg.sv | 21 ++
 rtl/sec_tick.sv | 32 +++
 rtl/score_timer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wam_pkg.sv
// rtl/wam_pkg.sv - shared types and constants for the whack-a-mole score/timer
package wam_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BLANK = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tens digits show blank instead of a leading zero
    function automatic digit_t blank_zero(input digit_t d);
        return (d == '0) ? BLANK : d;
    endfunction

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - game-second prescaler producing a one-cycle tick
module sec_tick #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_HZ);
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign tick      = enable && w_at_last;

    // Count 0..CLK_HZ-1 while enabled; a restart clears the phase
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_last ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/score_timer.sv
// rtl/score_timer.sv - game FSM with BCD score counter and countdown timer
module score_timer
    import wam_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int GAME_SECONDS = 30
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   start,
    input  logic   hit,
    output digit_t score_tens,
    output digit_t score_ones,
    output digit_t time_tens,
    output digit_t time_ones,
    output logic   digit_en,
    output logic   running,
    output logic   game_over
);

    localparam digit_t TENS_INIT = DIGIT_W'(GAME_SECONDS / 10);
    localparam digit_t ONES_INIT = DIGIT_W'(GAME_SECONDS % 10);

    state_t r_state;
    state_t w_state_next;
    logic   r_start_q;
    logic   r_hit_q;
    logic   r_digit_en;
    digit_t r_score_tens;
    digit_t r_score_ones;
    digit_t r_time_tens;
    digit_t r_time_ones;

    logic w_start_edge;
    logic w_hit_edge;
    logic w_load;
    logic w_tick;
    logic w_run;
    logic w_last_sec;
    logic w_score_max;

    // r_digit_en is low for the first cycle after release, so a level held
    // through reset is sampled as the previous value rather than seen as an edge
    assign w_start_edge = start && !r_start_q && r_digit_en;
    assign w_hit_edge   = hit && !r_hit_q && r_digit_en;
    assign w_run        = (r_state == RUN);
    assign w_last_sec   = (r_time_tens == '0) && (r_time_ones == 4'd1);
    assign w_score_max  = (r_score_tens == 4'd9) && (r_score_ones == 4'd9);

    sec_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_tick (
        .clock (clock),
        .reset (reset),
        .clear (w_load),
        .enable(w_run),
        .tick  (w_tick)
    );

    // Input sampling for edge detection and display enable
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_start_q  <= 1'b0;
            r_hit_q    <= 1'b0;
            r_digit_en <= 1'b0;
        end else begin
            r_start_q  <= start;
            r_hit_q    <= hit;
            r_digit_en <= 1'b1;
        end
    end

    // Game state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start launches a game from IDLE/DONE, last tick ends it
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_edge) begin
                    w_state_next = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                if (w_tick && w_last_sec) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // BCD countdown, one step per game second
    always_ff @(posedge clock) begin
        if (!reset || w_load) begin
            r_time_tens <= TENS_INIT;
            r_time_ones <= ONES_INIT;
        end else if (w_tick) begin
            if (r_time_ones == '0) begin
                r_time_tens <= r_time_tens - 4'd1;
                r_time_ones <= 4'd9;
            end else begin
                r_time_ones <= r_time_ones - 4'd1;
            end
        end
    end

    // BCD score, one per hit edge in RUN, saturating at 99
    always_ff @(posedge clock) begin
        if (!reset || w_load) begin
            r_score_tens <= '0;
            r_score_ones <= '0;
        end else if (w_run && w_hit_edge && !w_score_max) begin
            if (r_score_ones == 4'd9) begin
                r_score_tens <= r_score_tens + 4'd1;
                r_score_ones <= '0;
            end else begin
                r_score_ones <= r_score_ones + 4'd1;
            end
        end
    end

    assign score_tens = blank_zero(r_score_tens);
    assign score_ones = r_score_ones;
    assign time_tens  = blank_zero(r_time_tens);
    assign time_ones  = r_time_ones;
    assign digit_en   = r_digit_en;
    assign running    = (r_state == RUN);
    assign game_over  = (r_state == DONE);

endmodule
